pc_run_controller: RTL and testbench
====================================

Name: pc_run_controller

Overview:
Sequences program-counter updates in the single-cycle RISC-V core. It drives the PC load enable from four inputs: the decoder's stop flag (ECALL/EBREAK/FENCE class), a data-memory busy signal, and debug resume/step pulses. It halts on stop instructions, supports resume-over-stop and single-step, stalls on memory busy with a watchdog that escalates to a fault state, and counts retired instructions. It sits between the decoder/memory interface and the PC register.

Parameters:
TIMEOUT, 255, max consecutive mem_busy cycles before FAULT; 0 disables watchdog
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
stop_flag  input  1  current instruction is a stop instruction (from decoder)
mem_busy  input  1  data memory not ready; current instruction must not retire
resume  input  1  debug pulse: leave HALT and run
step  input  1  debug pulse: execute exactly one instruction from HALT
pc_load  output  1  PC register load enable (combinational from state and inputs)
halted  output  1  state == HALT
fault  output  1  state == FAULT
state  output  2  RUN=0, HALT=1, STEP=2, FAULT=3
retired_count  output  CNT_W  number of cycles with pc_load=1 since reset

Behaviour:
- Reset: while rst=1, pc_load=1 so the PC takes its reset vector. On the next edge: state=RUN, retired_count=0, stall_cnt=0, skip=0. rst from any state, including FAULT or mid-stall, returns to RUN.
- Internal: skip (1 bit) and stall_cnt (clog2(TIMEOUT+1) bits).
- RUN:
  - mem_busy=1: pc_load=0, stall_cnt++, stay in RUN; stop_flag is ignored until mem_busy drops.
  - mem_busy=0 and stop_flag=1 and skip=0: pc_load=0, next=HALT. The PC stays on the stop instruction.
  - Otherwise: pc_load=1, skip<=0.
- HALT:
  - pc_load=0.
  - resume=1: next=RUN, skip<=1.
  - else step=1: next=STEP.
  - resume and step together: resume wins.
- STEP:
  - pc_load = !mem_busy; stop_flag is ignored, so the step executes over a stop instruction.
  - First cycle with mem_busy=0: the instruction retires, next=HALT.
- FAULT: pc_load=0; only rst exits.
- skip: set on resume from HALT. The first retiring instruction in RUN ignores stop_flag, so resume does not re-halt on the same instruction. skip clears on that retirement.
- Watchdog:
  - stall_cnt clears on any cycle with mem_busy=0, or in HALT/FAULT.
  - In RUN/STEP with TIMEOUT!=0, if mem_busy=1 and stall_cnt==TIMEOUT-1, next=FAULT. FAULT is entered after exactly TIMEOUT busy cycles.
- retired_count increments on every non-reset cycle with pc_load=1, and wraps modulo 2^CNT_W.
- resume/step outside HALT are ignored, not latched.
- No output is registered except state, retired_count, and the flags derived from state. Latency from stop_flag to pc_load=0 is zero cycles.

Decomposition:
- Shared core package holds the state encoding constants (RUN/HALT/STEP/FAULT) and the stop-opcode constants used by the decoder for stop_flag.
- Natural sub-module: stall_watchdog, which owns stall_cnt, the TIMEOUT compare and the timeout output. The FSM and retire counter stay in the top.

Test Plan:
- Reset then free run: rst for 2 cycles, then 10 cycles with stop=0 and busy=0 -> pc_load=1 every cycle, retired_count=10, state=RUN.
- Halt and resume: stop_flag=1 at cycle 5 -> pc_load=0 that cycle, state=HALT next. Hold stop_flag=1 and pulse resume -> one pc_load=1 cycle, then RUN. Next stop_flag halts again.
- Single-step: from HALT, step pulse with busy=1 for 3 cycles then 0 -> pc_load=1 only on the 4th cycle, retired_count+1, back to HALT. Step with resume in the same cycle -> RUN.
- Stall priority: in RUN, busy=1 and stop=1 for 4 cycles, then busy=0 with stop=1 -> pc_load=0 throughout, HALT entered only after busy drops.
- Watchdog: TIMEOUT=4, busy held high -> FAULT after cycle 4, pc_load=0. resume/step ignored in FAULT. rst -> RUN with retired_count=0.
- Wrap and mid-operation reset: CNT_W=4, 17 retirements -> retired_count=1. Assert rst during STEP -> pc_load=1 while rst is high, state=RUN after.

Source files
------------

// File: rtl/pc_run_controller_pkg.sv
// pc_run_controller_pkg: run-control state encoding, stop opcodes and sizing helper
package pc_run_controller_pkg;
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_STEP  = 2'd2,
    ST_FAULT = 2'd3
  } run_state_e;
  // Opcodes the decoder flags as stop instructions (ECALL/EBREAK and FENCE class)
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  function automatic int stall_w(input int t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction
endpackage

// File: rtl/pc_run_controller_stall_watchdog.sv
// pc_run_controller_stall_watchdog: counts consecutive busy cycles and flags the timeout
module pc_run_controller_stall_watchdog
  import pc_run_controller_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic mem_busy,
  output logic timeout
);
  localparam int SW = stall_w(TIMEOUT);
  logic [SW-1:0] stall_cnt;
  always_ff @(posedge clk)
    stall_cnt <= (rst || !active || !mem_busy) ? '0 : stall_cnt + 1'b1;
  assign timeout = (TIMEOUT != 0) && active && mem_busy && (stall_cnt == SW'(TIMEOUT - 1));
endmodule

// File: rtl/pc_run_controller.sv
// pc_run_controller: PC load sequencing with halt/resume/step, stall watchdog and retire counter
module pc_run_controller
  import pc_run_controller_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stop_flag,
  input  logic             mem_busy,
  input  logic             resume,
  input  logic             step,
  output logic             pc_load,
  output logic             halted,
  output logic             fault,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] retired_count
);
  run_state_e st, st_nxt;
  logic skip, skip_nxt, load, timeout;
  pc_run_controller_stall_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .active  (st == ST_RUN || st == ST_STEP),
    .mem_busy(mem_busy),
    .timeout (timeout)
  );
  always_comb begin
    st_nxt   = st;
    skip_nxt = skip;
    load     = 1'b0;
    case (st)
      ST_RUN: begin
        if (mem_busy) st_nxt = timeout ? ST_FAULT : ST_RUN;
        else if (stop_flag && !skip) st_nxt = ST_HALT;
        else begin
          load     = 1'b1;
          skip_nxt = 1'b0;
        end
      end
      ST_HALT: begin
        st_nxt   = resume ? ST_RUN : (step ? ST_STEP : ST_HALT);
        skip_nxt = resume ? 1'b1 : skip;
      end
      ST_STEP: begin
        load   = !mem_busy;
        st_nxt = timeout ? ST_FAULT : (mem_busy ? ST_STEP : ST_HALT);
      end
      default: st_nxt = ST_FAULT;
    endcase
  end
  // While reset is held the PC must take its reset vector
  assign pc_load = rst || load;
  always_ff @(posedge clk) begin
    st            <= rst ? ST_RUN : st_nxt;
    skip          <= rst ? 1'b0 : skip_nxt;
    retired_count <= rst ? '0 : retired_count + CNT_W'(load);
  end
  assign state  = st;
  assign halted = (st == ST_HALT);
  assign fault  = (st == ST_FAULT);
endmodule

// File: tb/tb_pc_run_controller.sv
// tb_pc_run_controller: table vectors, directed corner sequences and random run vs reference model
module tb_pc_run_controller;
  localparam int TO = 4;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic rst = 1'b1, stop_flag = 1'b0, mem_busy = 1'b0, resume = 1'b0, step = 1'b0;
  logic pc_load, halted, fault;
  logic [1:0] state;
  logic [CW-1:0] retired_count;
  int checks = 0, failures = 0;
  int m_st, m_busy, m_cnt;
  bit m_skip;

  pc_run_controller #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stop_flag(stop_flag), .mem_busy(mem_busy),
    .resume(resume), .step(step), .pc_load(pc_load), .halted(halted),
    .fault(fault), .state(state), .retired_count(retired_count)
  );
  always #5 clk = ~clk;

  typedef struct {
    bit r, s, b, rs, sp;
    bit pc;
    int st;
    int cnt;
  } vec_t;
  vec_t tbl[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: modes 0=run 1=halt 2=step 3=fault; watchdog counts busy cycles directly
  task automatic cyc(input bit r, s, b, rs, sp);
    bit exp_pc;
    rst = r; stop_flag = s; mem_busy = b; resume = rs; step = sp;
    #2;
    exp_pc = r || (m_st == 0 && !b && !(s && !m_skip)) || (m_st == 2 && !b);
    chk("pc_load", 32'(pc_load), 32'(exp_pc));
    chk("state", 32'(state), 32'(m_st));
    chk("retired_count", 32'(retired_count), 32'(m_cnt));
    chk("halted", 32'(halted), 32'(m_st == 1));
    chk("fault", 32'(fault), 32'(m_st == 3));
    @(posedge clk); #1;
    if (r) begin
      m_st = 0; m_skip = 0; m_busy = 0; m_cnt = 0;
    end else begin
      m_cnt = (m_cnt + int'(exp_pc)) % (1 << CW);
      m_busy = (b && (m_st == 0 || m_st == 2)) ? m_busy + 1 : 0;
      if ((m_st == 0 || m_st == 2) && TO != 0 && m_busy == TO) m_st = 3;
      else if (m_st == 0) begin
        if (exp_pc) m_skip = 0;
        else if (!b && s) m_st = 1;
      end else if (m_st == 1) begin
        if (rs) begin m_st = 0; m_skip = 1; end
        else if (sp) m_st = 2;
      end else if (m_st == 2 && !b) m_st = 1;
    end
  endtask

  initial begin
    tbl = '{
      '{0,0,0,0,0, 1, 0, 0}, '{0,1,0,0,0, 0, 0, 1}, '{0,1,0,0,0, 0, 1, 1},
      '{0,1,0,1,0, 0, 1, 1}, '{0,1,0,0,0, 1, 0, 1}, '{0,1,0,0,0, 0, 0, 2},
      '{0,0,0,0,1, 0, 1, 2}, '{0,0,1,0,0, 0, 2, 2}, '{0,0,1,0,0, 0, 2, 2},
      '{0,0,1,0,0, 0, 2, 2}, '{0,1,0,0,0, 1, 2, 2}, '{0,0,0,1,1, 0, 1, 3},
      '{0,0,0,0,0, 1, 0, 3}, '{0,1,1,0,0, 0, 0, 4}, '{0,1,1,0,0, 0, 0, 4},
      '{0,1,1,0,0, 0, 0, 4}, '{0,1,0,0,0, 0, 0, 4}, '{0,0,0,0,0, 0, 1, 4}
    };
    @(posedge clk); #1;
    m_st = 0; m_skip = 0; m_busy = 0; m_cnt = 0;
    // Reset then free run
    cyc(1,0,0,0,0);
    cyc(1,0,0,0,0);
    repeat (10) cyc(0,0,0,0,0);
    #2 chk("free_run_cnt", 32'(retired_count), 32'd10);
    chk("free_run_state", 32'(state), 32'd0);
    // Table: halt/resume, step over stop, resume+step, stall priority
    cyc(1,0,0,0,0);
    foreach (tbl[i]) begin
      rst = tbl[i].r; stop_flag = tbl[i].s; mem_busy = tbl[i].b; resume = tbl[i].rs; step = tbl[i].sp;
      #1;
      chk($sformatf("tbl%0d_pc", i), 32'(pc_load), 32'(tbl[i].pc));
      chk($sformatf("tbl%0d_st", i), 32'(state), 32'(tbl[i].st));
      chk($sformatf("tbl%0d_cnt", i), 32'(retired_count), 32'(tbl[i].cnt));
      #(-1 + 1);
      cyc(tbl[i].r, tbl[i].s, tbl[i].b, tbl[i].rs, tbl[i].sp);
    end
    // Watchdog: exactly TO busy cycles reach FAULT; debug pulses ignored there
    cyc(1,0,0,0,0);
    cyc(0,0,0,0,0);
    repeat (TO) cyc(0,0,1,0,0);
    #2 chk("wd_fault", 32'(state), 32'd3);
    cyc(0,0,0,1,0);
    cyc(0,0,0,0,1);
    cyc(0,1,0,1,1);
    #2 chk("wd_stays_fault", 32'(fault), 32'd1);
    cyc(1,0,0,0,0);
    #2 chk("wd_rst_cnt", 32'(retired_count), 32'd0);
    chk("wd_rst_state", 32'(state), 32'd0);
    // Busy one short of timeout must not fault
    repeat (TO - 1) cyc(0,0,1,0,0);
    cyc(0,0,0,0,0);
    #2 chk("wd_no_fault", 32'(state), 32'd0);
    // Counter wrap
    cyc(1,0,0,0,0);
    repeat (17) cyc(0,0,0,0,0);
    #2 chk("wrap_cnt", 32'(retired_count), 32'd1);
    // Reset in the middle of a busy STEP
    cyc(0,1,0,0,0);
    cyc(0,0,0,0,1);
    cyc(0,0,1,0,0);
    #2 chk("mid_step_state", 32'(state), 32'd2);
    rst = 1'b1; #1;
    chk("mid_step_rst_pc", 32'(pc_load), 32'd1);
    cyc(1,0,1,0,0);
    #2 chk("mid_step_after_rst", 32'(state), 32'd0);
    // Random run against the model
    for (int n = 0; n < 3000; n++) begin
      bit r, s, b, rs, sp;
      r  = ($urandom_range(0, 99) == 0);
      s  = ($urandom_range(0, 3) == 0);
      b  = (n % 200 > 190) ? 1'b1 : ($urandom_range(0, 9) < 3);
      rs = ($urandom_range(0, 9) == 0);
      sp = ($urandom_range(0, 7) == 0);
      cyc(r, s, b, rs, sp);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
